parking_gate_arbiter: RTL and testbench
=======================================

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 Parameter OPEN_TIME, default 8, barrier-open duration in clk cycles (1..255).
REQ-002 Parameter CNT_W, default 16, width of capacity and occupancy values.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  lot open; 0 means entries refused.
REQ-006 uni_cap  input  CNT_W  current university-section capacity, from the time schedule.
REQ-007 gen_cap  input  CNT_W  current general-section capacity, from the time schedule.
REQ-008 req  input  4  gate request levels; bits 0-1 are entry gates, bits 2-3 are exit gates.
REQ-009 req_uni  input  4  per-gate car class, 1 = university car; sampled with req.
REQ-010 grant  output  4  one-hot, one-cycle pulse when a request is accepted.
REQ-011 deny  output  4  one-hot, one-cycle pulse when a request is refused.
REQ-012 gate_open  output  4  barrier-open level, per gate.
REQ-013 uni_count  output  CNT_W  university cars parked.
REQ-014 gen_count  output  CNT_W  general cars parked.
REQ-015 uni_full  output  1  high when uni_count >= uni_cap.
REQ-016 gen_full  output  1  high when gen_count >= gen_cap.

Function
REQ-017 Each gate shall run its own FSM with states IDLE, WAIT, OPEN and REL.
REQ-018 IDLE->WAIT: at an edge with req[i]=1, latching req_uni[i] into the gate's class bit.
REQ-019 WAIT: the gate remains pending until the arbiter selects it; req changes are ignored while pending.
REQ-020 The arbiter shall select at most one WAIT gate per cycle, round-robin; after deciding gate i, the next search starts at (i+1) mod 4.
REQ-021 Entry decision: grant if enable=1 and the latched class count < its cap; otherwise deny.
REQ-022 Exit decision: grant if the latched class count > 0; otherwise deny. Exits are independent of enable.
REQ-023 On grant, at the same edge: the count shall change by +1 for entry or -1 for exit, grant[i] shall pulse, and the gate shall enter OPEN.
REQ-024 On deny, at the same edge: deny[i] shall pulse, the count is unchanged, and the gate shall enter REL.
REQ-025 OPEN: gate_open[i] shall be 1 for exactly OPEN_TIME cycles starting the cycle after the grant edge, then the gate enters REL.
REQ-026 REL: the gate shall hold until req[i]=0 is sampled, then return to IDLE. A new request requires req to fall and rise again.
REQ-027 Latency: if req rises before edge k, the gate enters WAIT at k; the earliest grant or deny is visible after edge k+1.
REQ-028 Counts shall saturate: never below 0, never above 2^CNT_W-1.
REQ-029 If a cap drops below its count, the count is kept (no eviction), the full flag asserts, and further entries of that class are denied until the count falls below the cap.
REQ-030 uni_full and gen_full shall be combinational compares of the current count and cap.
REQ-031 Cap changes shall take effect on the first decision made after the change.

Reset
REQ-032 While rst=1 at an edge: every gate goes to IDLE, counts go to 0, grant/deny/gate_open go to 0, and the round-robin pointer goes to gate 0.
REQ-033 Reset asserted mid-OPEN shall drop gate_open the next cycle; a pending WAIT request is discarded without a grant or deny.
REQ-034 Outputs after reset: uni_full = (uni_cap == 0), gen_full = (gen_cap == 0).

Verification
REQ-035 Basic entry. Stimulus: rst, then enable=1, gen_cap=200, req[0]=1, req_uni[0]=0. Response: grant[0] pulses 2 edges after the rise, gen_count=1, gate_open[0] high for 8 cycles, gate back in IDLE after req[0] drops.
REQ-036 Full lot. Stimulus: uni_cap=2, three successive uni entries on gate 1. Response: grant, grant, deny; uni_count=2; uni_full=1; no gate_open on the denied request.
REQ-037 Round-robin. Stimulus: req[3:0]=1111 simultaneously, counts large and caps large. Response: decisions on consecutive cycles in order gate 0, 1, 2, 3; exactly one grant/deny bit per cycle.
REQ-038 Exit from empty. Stimulus: exit on gate 2 with gen_count=0. Response: deny[2] pulses and gen_count stays 0. Then enable=0 with an entry on gate 0: deny[0] pulses. Then an exit on gate 3 with gen_count=5: grant[3] pulses and gen_count=4.
REQ-039 Cap shrink. Stimulus: uni_count=450, uni_cap changes 500->400. Response: uni_full=1 and count stays 450; entries are denied, exits are granted, and entries are granted again once the count is 399.
REQ-040 Reset mid-operation. Stimulus: rst pulsed during OPEN with another gate in WAIT. Response: all outputs 0 next cycle, counts 0, and no grant for the discarded request.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_arbiter
// Purpose  : Four-gate parking barrier controller. Gates 0-1 are entries and
//            gates 2-3 are exits. Each gate runs its own small FSM
//            (IDLE/WAIT/OPEN/REL). A round-robin arbiter decides at most one
//            waiting gate per cycle against the occupancy counts of the
//            university and general sections.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            enable               - lot open (entries refused when 0)
//            uni_cap, gen_cap     - current section capacities
//            req, req_uni         - per-gate request level and car class
//            grant, deny          - one-cycle decision pulses (one-hot)
//            gate_open            - per-gate barrier-open level
//            uni_count, gen_count - cars parked per section
//            uni_full, gen_full   - count >= cap (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module parking_gate_arbiter #(
    parameter int OPEN_TIME = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] uni_cap,
    input  logic [CNT_W-1:0] gen_cap,
    input  logic [3:0]       req,
    input  logic [3:0]       req_uni,
    output logic [3:0]       grant,
    output logic [3:0]       deny,
    output logic [3:0]       gate_open,
    output logic [CNT_W-1:0] uni_count,
    output logic [CNT_W-1:0] gen_count,
    output logic             uni_full,
    output logic             gen_full
);

    localparam int         c_NUM_GATES = 4;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_OPEN   = 2'd2;
    localparam logic [1:0] c_ST_REL    = 2'd3;
    // Timer counts down to zero, so loading OPEN_TIME-1 yields OPEN_TIME cycles.
    localparam logic [7:0] c_OPEN_LOAD = 8'(OPEN_TIME - 1);

    logic [1:0]       r_state      [c_NUM_GATES];
    logic [1:0]       w_next_state [c_NUM_GATES];
    logic [7:0]       r_timer      [c_NUM_GATES];
    logic [3:0]       r_cls;
    logic [3:0]       r_grant;
    logic [3:0]       r_deny;
    logic [1:0]       r_rr_ptr;
    logic [CNT_W-1:0] r_uni_count;
    logic [CNT_W-1:0] r_gen_count;

    logic [3:0]       w_pend;
    logic [3:0]       w_sel_hit;
    logic             w_sel_valid;
    logic [1:0]       w_sel_idx;
    logic [1:0]       w_cand;
    logic             w_is_entry;
    logic             w_sel_cls;
    logic [CNT_W-1:0] w_cur_count;
    logic [CNT_W-1:0] w_cur_cap;
    logic             w_accept;

    // ------------------------------------------------------------------
    // Per-gate status views
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < c_NUM_GATES; g++) begin : g_gate
            assign w_pend[g]    = (r_state[g] == c_ST_WAIT);
            assign gate_open[g] = (r_state[g] == c_ST_OPEN);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin selection: scan offsets from highest to lowest so the
    // waiting gate closest to the pointer is the last (winning) assignment.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = r_rr_ptr;
        w_cand      = 2'd0;
        for (int k = c_NUM_GATES - 1; k >= 0; k--) begin
            w_cand = r_rr_ptr + 2'(k);
            if (w_pend[w_cand]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_hit = 4'b0000;
        if (w_sel_valid) begin
            w_sel_hit[w_sel_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Decision for the selected gate. Entry needs count < cap, which also
    // keeps the count below its maximum; exit needs count > 0, so counts
    // saturate at both ends without extra guards.
    // ------------------------------------------------------------------
    always_comb begin
        w_is_entry  = ~w_sel_idx[1];
        w_sel_cls   = r_cls[w_sel_idx];
        w_cur_count = w_sel_cls ? r_uni_count : r_gen_count;
        w_cur_cap   = w_sel_cls ? uni_cap : gen_cap;
        if (w_is_entry) begin
            w_accept = enable && (w_cur_count < w_cur_cap);
        end else begin
            w_accept = (w_cur_count != '0);
        end
    end

    // ------------------------------------------------------------------
    // Gate FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        for (int g = 0; g < c_NUM_GATES; g++) begin
            w_next_state[g] = r_state[g];
            case (r_state[g])
                c_ST_IDLE: if (req[g]) w_next_state[g] = c_ST_WAIT;
                // req is deliberately ignored while pending.
                c_ST_WAIT: if (w_sel_hit[g]) w_next_state[g] = w_accept ? c_ST_OPEN : c_ST_REL;
                c_ST_OPEN: if (r_timer[g] == 8'd0) w_next_state[g] = c_ST_REL;
                c_ST_REL:  if (!req[g]) w_next_state[g] = c_ST_IDLE;
                default:   w_next_state[g] = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < c_NUM_GATES; g++) begin
            if (rst) begin
                r_state[g] <= c_ST_IDLE;
            end else begin
                r_state[g] <= w_next_state[g];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: class latch, open timer, decision pulses, pointer, counts
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < c_NUM_GATES; g++) begin
                r_timer[g] <= 8'd0;
            end
            r_cls       <= 4'b0000;
            r_grant     <= 4'b0000;
            r_deny      <= 4'b0000;
            r_rr_ptr    <= 2'd0;
            r_uni_count <= '0;
            r_gen_count <= '0;
        end else begin
            for (int g = 0; g < c_NUM_GATES; g++) begin
                if ((r_state[g] == c_ST_IDLE) && req[g]) begin
                    r_cls[g] <= req_uni[g];
                end
                if (w_sel_hit[g] && w_accept) begin
                    r_timer[g] <= c_OPEN_LOAD;
                end else if ((r_state[g] == c_ST_OPEN) && (r_timer[g] != 8'd0)) begin
                    r_timer[g] <= r_timer[g] - 8'd1;
                end
            end

            r_grant <= w_accept ? w_sel_hit : 4'b0000;
            r_deny  <= w_accept ? 4'b0000 : w_sel_hit;

            if (w_sel_valid) begin
                r_rr_ptr <= w_sel_idx + 2'd1;
            end

            if (w_sel_valid && w_accept) begin
                if (w_sel_cls) begin
                    r_uni_count <= w_is_entry ? r_uni_count + 1'b1 : r_uni_count - 1'b1;
                end else begin
                    r_gen_count <= w_is_entry ? r_gen_count + 1'b1 : r_gen_count - 1'b1;
                end
            end
        end
    end

    assign grant     = r_grant;
    assign deny      = r_deny;
    assign uni_count = r_uni_count;
    assign gen_count = r_gen_count;
    // Full flags follow cap changes immediately, including a cap below count.
    assign uni_full  = (r_uni_count >= uni_cap);
    assign gen_full  = (r_gen_count >= gen_cap);

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_gate_arbiter
// Purpose  : Directed self-checking bench for parking_gate_arbiter with
//            hand-computed expectations (OPEN_TIME = 8, CNT_W = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_gate_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] uni_cap;
    logic [15:0] gen_cap;
    logic [3:0]  req;
    logic [3:0]  req_uni;
    logic [3:0]  grant;
    logic [3:0]  deny;
    logic [3:0]  gate_open;
    logic [15:0] uni_count;
    logic [15:0] gen_count;
    logic        uni_full;
    logic        gen_full;

    int n_assert = 0;
    int n_fail   = 0;

    parking_gate_arbiter #(
        .OPEN_TIME (8),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .uni_cap   (uni_cap),
        .gen_cap   (gen_cap),
        .req       (req),
        .req_uni   (req_uni),
        .grant     (grant),
        .deny      (deny),
        .gate_open (gate_open),
        .uni_count (uni_count),
        .gen_count (gen_count),
        .uni_full  (uni_full),
        .gen_full  (gen_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request: req high for one edge (enters WAIT), decision at
    // the next edge, then enough idle edges for OPEN (8) + REL + IDLE.
    task automatic do_req(input int gate, input logic uni,
                          output logic [3:0] g, output logic [3:0] d, output logic [3:0] o);
        req          = 4'b0000;
        req_uni      = 4'b0000;
        req[gate]    = 1'b1;
        req_uni[gate] = uni;
        tick();
        req = 4'b0000;
        tick();
        g = grant;
        d = deny;
        o = gate_open;
        repeat (11) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g, d, o;
        int n_open;
        int n_ok;
        logic [3:0] acc;

        rst = 1'b1; enable = 1'b0; uni_cap = 16'd0; gen_cap = 16'd200;
        req = 4'b0000; req_uni = 4'b0000;
        tick(); tick();
        check("rst_grant", grant, 4'b0000);
        check("rst_deny", deny, 4'b0000);
        check("rst_open", gate_open, 4'b0000);
        check("rst_counts", {uni_count, gen_count}, 32'd0);
        check("rst_uni_full", uni_full, 1'b1);
        check("rst_gen_full", gen_full, 1'b0);

        // Basic entry, gate 0, general class
        rst = 1'b0; enable = 1'b1; uni_cap = 16'd500;
        req = 4'b0001; req_uni = 4'b0000;
        tick();
        check("s1_no_decision_at_k", {grant, deny}, 8'h00);
        tick();
        check("s1_grant", grant, 4'b0001);
        check("s1_deny", deny, 4'b0000);
        check("s1_gen_count", gen_count, 16'd1);
        req = 4'b0000;
        n_open = gate_open[0] ? 1 : 0;
        tick();
        check("s1_grant_pulse", grant, 4'b0000);
        if (gate_open[0]) n_open++;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (gate_open[0]) n_open++;
        end
        check("s1_open_cycles", n_open, 8);
        do_req(0, 1'b0, g, d, o);
        check("s1_reentry_grant", g, 4'b0001);
        check("s1_reentry_count", gen_count, 16'd2);

        // Full lot: uni_cap = 2, three uni entries on gate 1
        uni_cap = 16'd2;
        do_req(1, 1'b1, g, d, o);
        check("s2_first_grant", g, 4'b0010);
        do_req(1, 1'b1, g, d, o);
        check("s2_second_grant", g, 4'b0010);
        check("s2_uni_full", uni_full, 1'b1);
        do_req(1, 1'b1, g, d, o);
        check("s2_third_deny", {g, d}, {4'b0000, 4'b0010});
        check("s2_no_open", o, 4'b0000);
        check("s2_uni_count", uni_count, 16'd2);

        // Uni exit on gate 3 brings the pointer back to gate 0
        uni_cap = 16'd500;
        do_req(3, 1'b1, g, d, o);
        check("s3_prep_exit", g, 4'b1000);
        check("s3_prep_uni", uni_count, 16'd1);

        // Round-robin with all four gates requesting together (general class)
        req = 4'b1111; req_uni = 4'b0000;
        tick();
        req = 4'b0000;
        tick();
        check("s3_rr0", {grant, deny}, {4'b0001, 4'b0000});
        check("s3_rr0_cnt", gen_count, 16'd3);
        tick();
        check("s3_rr1", {grant, deny}, {4'b0010, 4'b0000});
        check("s3_rr1_cnt", gen_count, 16'd4);
        tick();
        check("s3_rr2", {grant, deny}, {4'b0100, 4'b0000});
        check("s3_rr2_cnt", gen_count, 16'd3);
        tick();
        check("s3_rr3", {grant, deny}, {4'b1000, 4'b0000});
        check("s3_rr3_cnt", gen_count, 16'd2);
        repeat (14) tick();

        // Reset, then exits from empty and entries while closed
        rst = 1'b1; gen_cap = 16'd0;
        tick();
        check("s4_rst_gen_full", gen_full, 1'b1);
        check("s4_rst_uni_full", uni_full, 1'b0);
        check("s4_rst_counts", {uni_count, gen_count}, 32'd0);
        rst = 1'b0; gen_cap = 16'd200;
        do_req(2, 1'b0, g, d, o);
        check("s4_exit_empty", {g, d}, {4'b0000, 4'b0100});
        check("s4_exit_empty_cnt", gen_count, 16'd0);
        enable = 1'b0;
        do_req(0, 1'b0, g, d, o);
        check("s4_closed_deny", {g, d}, {4'b0000, 4'b0001});
        enable = 1'b1;
        n_ok = 0;
        for (int i = 0; i < 5; i++) begin
            do_req(0, 1'b0, g, d, o);
            if (g == 4'b0001) n_ok++;
        end
        check("s4_fill5", n_ok, 5);
        check("s4_gen5", gen_count, 16'd5);
        do_req(3, 1'b0, g, d, o);
        check("s4_exit_grant", g, 4'b1000);
        check("s4_gen4", gen_count, 16'd4);

        // Cap shrink: fill uni to 450 under cap 500, then cap 400
        n_ok = 0;
        for (int i = 0; i < 450; i++) begin
            do_req(1, 1'b1, g, d, o);
            if (g == 4'b0010) n_ok++;
        end
        check("s5_fill", n_ok, 450);
        check("s5_uni450", uni_count, 16'd450);
        check("s5_not_full", uni_full, 1'b0);
        uni_cap = 16'd400;
        #1;
        check("s5_full_after_shrink", uni_full, 1'b1);
        check("s5_count_kept", uni_count, 16'd450);
        do_req(0, 1'b1, g, d, o);
        check("s5_entry_denied", {g, d}, {4'b0000, 4'b0001});
        do_req(2, 1'b1, g, d, o);
        check("s5_exit_granted", g, 4'b0100);
        check("s5_uni449", uni_count, 16'd449);
        n_ok = 0;
        for (int i = 0; i < 49; i++) begin
            do_req(2, 1'b1, g, d, o);
            if (g == 4'b0100) n_ok++;
        end
        check("s5_drain", n_ok, 49);
        check("s5_uni400", uni_count, 16'd400);
        do_req(1, 1'b1, g, d, o);
        check("s5_deny_at_cap", {g, d}, {4'b0000, 4'b0010});
        do_req(3, 1'b1, g, d, o);
        check("s5_uni399", uni_count, 16'd399);
        do_req(0, 1'b1, g, d, o);
        check("s5_entry_again", {g, d}, {4'b0001, 4'b0000});
        check("s5_uni400_again", uni_count, 16'd400);

        // Reset while gate 0 is OPEN and gate 1 is WAIT
        req = 4'b0001; req_uni = 4'b0000;
        tick();
        req = 4'b0000;
        tick();
        check("s6_grant", grant, 4'b0001);
        tick(); tick(); tick();
        req = 4'b0010;
        tick();
        check("s6_still_open", gate_open, 4'b0001);
        rst = 1'b1; req = 4'b0000;
        tick();
        check("s6_rst_outs", {grant, deny, gate_open}, 12'h000);
        check("s6_rst_counts", {uni_count, gen_count}, 32'd0);
        rst = 1'b0;
        acc = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            acc = acc | grant | deny | gate_open;
        end
        check("s6_no_late_decision", acc, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
